// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// one-hot relation encoding {GT, LT, EQ}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic [2:0] REL_NONE = 3'b000;
  localparam logic [2:0] REL_GT   = 3'b100;
  localparam logic [2:0] REL_LT   = 3'b010;
  localparam logic [2:0] REL_EQ   = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans MSB to LSB, stops at the
// first differing bit and returns one-hot relation flags plus scan length.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// SCAN  | comparing a_q/b_q one bit per cycle from idx downwards
// DONE  | result held with out_valid=1 until out_ready
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int size  = 20,
  parameter int CNT_W = $clog2(size + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [size-1:0]  a,
  input  logic [size-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater_b,
  output logic             b_greater_a,
  output logic             a_equal_b,
  output logic [CNT_W-1:0] scan_cycles
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;

  cmp_state_t       state;
  logic [size-1:0]  a_q;
  logic [size-1:0]  b_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rel;

  // Decoded from registered state only: no combinational path from out_ready.
  assign in_ready    = (state == IDLE);
  assign a_greater_b = rel[2];
  assign b_greater_a = rel[1];
  assign a_equal_b   = rel[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      cnt         <= '0;
      rel         <= REL_NONE;
      out_valid   <= 1'b0;
      scan_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_W'(size - 1);
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt + 1'b1;
          if (a_q[idx] != b_q[idx]) begin
            rel         <= a_q[idx] ? REL_GT : REL_LT;
            scan_cycles <= cnt + 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            // Terminates before idx could wrap below zero.
            rel         <= REL_EQ;
            scan_cycles <= CNT_W'(size);
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rel       <= REL_NONE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: directed vector table,
// stall/reset-abort sequences and randomized operands against a reference model.
module tb_seq_magnitude_comparator;

  localparam int SIZE  = 20;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  a;
  logic [SIZE-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic             a_greater_b;
  logic             b_greater_a;
  logic             a_equal_b;
  logic [CNT_W-1:0] scan_cycles;

  int checks = 0;
  int errors = 0;

  seq_magnitude_comparator #(.size(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .a_greater_b(a_greater_b), .b_greater_a(b_greater_a),
    .a_equal_b(a_equal_b), .scan_cycles(scan_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] va;
    logic [SIZE-1:0] vb;
    logic            gt;
    logic            lt;
    logic            eq;
    int              cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: relation from plain comparison; scan length is size minus
  // the position of the highest differing bit, or size when equal.
  function automatic void model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                output logic gt, output logic lt, output logic eq,
                                output int cyc);
    logic [SIZE-1:0] d;
    int k;
    gt = (x > y);
    lt = (x < y);
    eq = (x == y);
    d = x ^ y;
    k = 0;
    while (d > 1) begin
      d = d >> 1;
      k++;
    end
    cyc = eq ? SIZE : SIZE - k;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One full operation: accept, count edges to out_valid, optionally stall.
  task automatic run_op(input string tag, input logic [SIZE-1:0] va, input logic [SIZE-1:0] vb,
                        input logic egt, input logic elt, input logic eeq,
                        input int ecyc, input int stall);
    int n;
    logic [2:0] held;
    wait_ready();
    a = va; b = vb; in_valid = 1'b1; out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < SIZE + 5) begin
      a = SIZE'($urandom); b = SIZE'($urandom);
      step();
      n++;
    end
    chk({tag, "_latency"}, n, ecyc);
    chk({tag, "_flags"}, {29'd0, a_greater_b, b_greater_a, a_equal_b}, {29'd0, egt, elt, eeq});
    chk({tag, "_scan_cycles"}, {{(32-CNT_W){1'b0}}, scan_cycles}, ecyc);
    chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    held = {egt, elt, eeq};
    for (int i = 0; i < stall; i++) begin
      a = SIZE'($urandom); b = SIZE'($urandom);
      step();
      chk({tag, "_stall_hold"},
          {22'd0, out_valid, in_ready, a_greater_b, b_greater_a, a_equal_b, CNT_W'(scan_cycles)},
          {22'd0, 1'b1, 1'b0, held, CNT_W'(ecyc)});
      if (i == stall - 1) out_ready = 1'b1;
    end
    step();
    chk({tag, "_release"}, {28'd0, out_valid, a_greater_b, b_greater_a, a_equal_b}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic gt, lt, eq;
    int cyc, n;
    logic [SIZE-1:0] ra, rb;

    vecs[0] = '{20'h80000, 20'h7FFFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{20'h00001, 20'h00002, 1'b0, 1'b1, 1'b0, 19};
    vecs[2] = '{20'hABCDE, 20'hABCDE, 1'b0, 1'b0, 1'b1, 20};
    vecs[3] = '{20'h00000, 20'hFFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{20'h00000, 20'h00000, 1'b0, 1'b0, 1'b1, 20};
    vecs[5] = '{20'h12345, 20'h12344, 1'b1, 1'b0, 1'b0, 20};
    vecs[6] = '{20'h00010, 20'h00000, 1'b1, 1'b0, 1'b0, 16};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_outputs", {28'd0, out_valid, a_greater_b, b_greater_a, a_equal_b}, 32'd0);
    chk("reset_scan_cycles", {{(32-CNT_W){1'b0}}, scan_cycles}, 32'd0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
             vecs[i].gt, vecs[i].lt, vecs[i].eq, vecs[i].cyc, 0);

    // Stall in DONE for 10 cycles with inputs wiggling.
    run_op("stall", 20'h00010, 20'h00000, 1'b1, 1'b0, 1'b0, 16, 10);

    // Reset at edge 5 of a long scan must suppress the result.
    wait_ready();
    a = 20'h00001; b = 20'h00000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("abort_no_early_valid", {31'd0, out_valid}, 32'd0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < SIZE + 5; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("abort_no_valid", n, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("after_abort", 20'h00005, 20'h00005, 1'b0, 1'b0, 1'b1, 20, 0);

    for (int i = 0; i < 40; i++) begin
      ra = SIZE'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (SIZE'(1) << $urandom_range(0, SIZE - 1));
        default: rb = SIZE'($urandom) >> $urandom_range(0, SIZE - 1);
      endcase
      model(ra, rb, gt, lt, eq, cyc);
      run_op($sformatf("rnd%0d", i), ra, rb, gt, lt, eq, cyc, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
